cs_y_collector: RTL and testbench
=================================

# cs_y_collector

Receive-side companion to the `CS` series-computation core. It samples the 10-bit `Y` result stream on every qualified cycle and discards the partial-window results produced before the 9-sample window first fills. Valid results are buffered in a small FIFO and presented to a downstream consumer over a valid/ready handshake. Results that arrive while the buffer is full are dropped, and the drops are reported through a sticky overflow flag and a saturating drop counter.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of 2, at least 2.
- `WARMUP`, default 9: window length of `CS`; the first `WARMUP-1` qualified `Y` values after reset or restart are discarded.
- `Y_W`, default 10: result width.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; when low, all state clears.
- `en`, in, 1: `y` at this rising edge is the result for a newly consumed `X` sample.
- `y`, in, `Y_W`: `Y` output of `CS`.
- `restart`, in, 1: synchronous; clears the warm-up count and flushes the FIFO.
- `m_data`, out, `Y_W`: FIFO head; forced to 0 when the FIFO is empty.
- `m_valid`, out, 1: FIFO is not empty.
- `m_ready`, in, 1: consumer accepts `m_data` this cycle.
- `level`, out, log2(`DEPTH`)+1: current FIFO occupancy.
- `overflow`, out, 1: sticky; set when a result was dropped.
- `drop_cnt`, out, 8: count of dropped results, saturates at 255.
- `clr_ovf`, in, 1: synchronous; clears `overflow` and `drop_cnt`.

## Operation
- FSM has two states:
  - WARM: entered on reset and on `restart`. Each `en` cycle increments `wcnt` and discards `y`. When `en` arrives with `wcnt == WARMUP-2`, the state moves to RUN at that edge; that sample is still discarded.
  - RUN: each `en` cycle is a push request. The state stays RUN until reset or `restart`.
- Net effect: the 9th qualified `y` after reset is the first value stored.
- Pop occurs when `m_valid && m_ready`.
- Push with FIFO not full: `y` is written at `wr_ptr`, and `wr_ptr` increments, wrapping modulo `DEPTH`.
- Push while full without a pop: `y` is dropped, `overflow` is set, and `drop_cnt` increments (saturating at 255).
- Push and pop in the same cycle while full: both are accepted; `level` is unchanged and nothing is dropped.
- Push and pop in the same cycle while empty: the push is accepted and the pop cannot occur (`m_valid` is 0); `level` becomes 1.
- Pointers are log2(`DEPTH`) bits wide. `level` is tracked separately; full is `level == DEPTH`.
- `restart`:
  - Sets the FSM to WARM, `wcnt` to 0, the pointers to 0 and `level` to 0.
  - Overrides any push or pop in the same cycle.
  - Does not touch `overflow` or `drop_cnt`.
- `clr_ovf` coinciding with a drop: the set wins, giving `overflow=1` and `drop_cnt=1`.
- `y` is not checked for X or Z; it is stored as received.

## Timing
- Reset values: `m_data=0`, `m_valid=0`, `level=0`, `overflow=0`, `drop_cnt=0`; FSM in WARM with `wcnt=0`.
- Push-to-visible latency is 1 cycle: a value pushed at edge n appears with `m_valid=1` after edge n.
- `m_data` is a combinational read of the head entry, masked to 0 when empty. It is stable while `m_valid && !m_ready`.
- `level`, `overflow` and `drop_cnt` are registered and update on the same edge as the event that changes them.
- Reset asserted mid-stream clears everything immediately; no partial state survives.
- Sustained throughput is 1 push and 1 pop per cycle.

## Structure
- Shared package `cs_pkg`:
  - `CS_X_W=8`, `CS_Y_W=10`, `CS_WARMUP=9`.
  - FSM enum `cs_col_state_t {WARM, RUN}`.
- Sub-module `cs_sync_fifo`: parameterised storage, pointers and `level`, with push, pop and flush ports.
- The top level holds the warm-up FSM, drop logic and overflow/`drop_cnt` logic.

## Test plan
- **Warm-up:** release reset; apply 12 `en` cycles with `y` = 0x001 to 0x00C and `m_ready=1`.
  - Expect exactly 4 outputs: 0x009, 0x00A, 0x00B, 0x00C, each appearing 1 cycle after its push.
- **Fill to full:** warm up, hold `m_ready=0`, push 20 values.
  - Expect `level=16` and `overflow=1` after the 17th push, with `drop_cnt=4`.
  - Then pop all 16 and expect the first 16 values in order.
- **Full, push and pop together:** at `level=16`, push 0x3FF with `m_ready=1`.
  - Expect `level=16`, no drop, the head popped, and 0x3FF at the tail.
- **Restart:** with `level=5` and `restart=1` alongside an `en` push.
  - Expect `level=0`, `m_valid=0`, and `overflow` unchanged.
  - The next 8 `en` cycles are discarded and the 9th is stored.
- **Clear/drop race and saturation:**
  - `clr_ovf` in the same cycle as a drop gives `overflow=1`, `drop_cnt=1`.
  - 300 drops give `drop_cnt=255`.
- **Async reset mid-stream:** pull `reset` low between edges with `level=7`.
  - All outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the CS series-computation receive path.
// Holds CS widths, window length and the collector FSM state type.
package cs_pkg;

    localparam int CS_X_W     = 8;
    localparam int CS_Y_W     = 10;
    localparam int CS_WARMUP  = 9;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } cs_col_state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous FIFO with flush, a separately tracked level, and a head read that reads 0 when empty.
// Ports: clk, reset (async active-low), push/wdata, pop, flush, rdata, empty, full, level.
module cs_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A pop makes room, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cs_y_collector.sv
// Collects CS Y results after the window fills, buffers them and reports drops.
// Ports: clk, reset, en, y, restart, m_data/m_valid/m_ready, level, overflow, drop_cnt, clr_ovf.
module cs_y_collector
    import cs_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WARMUP = CS_WARMUP,
    parameter int Y_W    = CS_Y_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [Y_W-1:0] y,
    input  logic           restart,
    output logic [Y_W-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [LW-1:0]  level,
    output logic           overflow,
    output logic [7:0]     drop_cnt,
    input  logic           clr_ovf
);

    localparam int WC_W = (WARMUP > 2) ? $clog2(WARMUP) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WARMUP - 2);

    cs_col_state_t   state;
    logic [WC_W-1:0] wcnt;
    logic            push_req;
    logic            pop;
    logic            empty;
    logic            full;
    logic            drop;

    assign m_valid  = !empty;
    assign pop      = m_valid && m_ready && !restart;
    assign push_req = en && (state == RUN) && !restart;
    assign drop     = push_req && full && !pop;

    cs_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (Y_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .wdata (y),
        .pop   (pop),
        .flush (restart),
        .rdata (m_data),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    // The sample seen with wcnt at its last value is still discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WARM;
            wcnt  <= '0;
        end else if (restart) begin
            state <= WARM;
            wcnt  <= '0;
        end else if (en && state == WARM) begin
            if (wcnt == WC_LAST) begin
                state <= RUN;
            end else begin
                wcnt <= wcnt + WC_W'(1);
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cs_y_collector.sv
// Self-checking bench for cs_y_collector: directed scenarios plus random traffic
// compared against a queue-based model of the collector.
module tb_cs_y_collector;

    localparam int DEPTH  = 16;
    localparam int WARMUP = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [9:0] y = '0;
    logic       restart = 1'b0;
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic [9:0] q[$];
    int         seen = 0;
    logic       m_ovf = 1'b0;
    int         m_dcnt = 0;

    cs_y_collector #(.DEPTH(DEPTH), .WARMUP(WARMUP), .Y_W(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .y        (y),
        .restart  (restart),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        seen   = 0;
        m_ovf  = 1'b0;
        m_dcnt = 0;
    endtask

    task automatic step(input logic e, input logic [9:0] yv, input logic rdy,
                        input logic rs, input logic clr);
        logic p;
        logic d;
        en = e; y = yv; m_ready = rdy; restart = rs; clr_ovf = clr;
        @(posedge clk);
        p = (q.size() != 0) && rdy;
        d = 1'b0;
        if (rs) begin
            q.delete();
            seen = 0;
        end else begin
            if (p) void'(q.pop_front());
            if (e) begin
                if (seen < WARMUP - 1) seen++;
                else if (q.size() < DEPTH) q.push_back(yv);
                else d = 1'b1;
            end
        end
        if (d) begin
            m_ovf  = 1'b1;
            m_dcnt = clr ? 1 : (m_dcnt >= 255 ? 255 : m_dcnt + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end
        #1;
        en = 1'b0; restart = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic warm();
        for (int i = 0; i < WARMUP - 1; i++) step(1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        nvec++;
        if (m_valid !== 1'b0 || m_data !== 10'd0 || level !== 5'd0 ||
            overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset: valid=%b data=%h level=%0d ovf=%b dcnt=%0d, need all 0",
                     m_valid, m_data, level, overflow, drop_cnt);
        end
    endtask

    task automatic test_warmup();
        int outs = 0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 10'(i), 1'b1, 1'b0, 1'b0);
            nvec++;
            if (i < WARMUP) begin
                if (m_valid !== 1'b0) begin
                    nerr++;
                    $display("FAIL warmup_discard[%0d]: valid=%b, need 0", i, m_valid);
                end
            end else begin
                if (m_valid !== 1'b1 || m_data !== 10'(i)) begin
                    nerr++;
                    $display("FAIL warmup_out[%0d]: valid=%b data=%h, need 1 %h",
                             i, m_valid, m_data, 10'(i));
                end
            end
            if (m_valid === 1'b1) outs++;
        end
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        nvec++;
        if (outs != 4 || m_valid !== 1'b0) begin
            nerr++;
            $display("FAIL warmup_count: outputs=%0d valid=%b, need 4 0", outs, m_valid);
        end
    endtask

    task automatic test_fill();
        logic [9:0] vals[20];
        do_reset();
        warm();
        for (int i = 0; i < 20; i++) begin
            vals[i] = 10'($urandom_range(0, 1023));
            step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
            if (i == 16) begin
                nvec++;
                if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
                    nerr++;
                    $display("FAIL fill_17: level=%0d ovf=%b dcnt=%0d, need 16 1 1",
                             level, overflow, drop_cnt);
                end
            end
        end
        nvec++;
        if (level !== 5'd16 || drop_cnt !== 8'd4) begin
            nerr++;
            $display("FAIL fill_20: level=%0d dcnt=%0d, need 16 4", level, drop_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (m_valid !== 1'b1 || m_data !== vals[i]) begin
                nerr++;
                $display("FAIL fill_pop[%0d]: valid=%b data=%h, need 1 %h",
                         i, m_valid, m_data, vals[i]);
            end
            step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        end
        nvec++;
        if (m_valid !== 1'b0 || level !== 5'd0) begin
            nerr++;
            $display("FAIL fill_empty: valid=%b level=%0d, need 0 0", m_valid, level);
        end
    endtask

    task automatic test_full_pushpop();
        logic [9:0] vals[16];
        do_reset();
        warm();
        for (int i = 0; i < 16; i++) begin
            vals[i] = 10'($urandom_range(0, 1022));
            step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd16 || overflow !== 1'b0 || drop_cnt !== 8'd0 || m_data !== vals[1]) begin
            nerr++;
            $display("FAIL full_pushpop: level=%0d ovf=%b dcnt=%0d head=%h, need 16 0 0 %h",
                     level, overflow, drop_cnt, m_data, vals[1]);
        end
        for (int i = 0; i < 15; i++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd1 || m_data !== 10'h3FF) begin
            nerr++;
            $display("FAIL full_tail: level=%0d data=%h, need 1 3ff", level, m_data);
        end
    endtask

    task automatic test_restart();
        logic [9:0] v;
        do_reset();
        warm();
        for (int i = 0; i < 17; i++) step(1'b1, 10'(i + 100), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd5) begin
            nerr++;
            $display("FAIL restart_pre: level=%0d, need 5", level);
        end
        step(1'b1, 10'h2AA, 1'b1, 1'b1, 1'b0);
        nvec++;
        if (level !== 5'd0 || m_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL restart: level=%0d valid=%b ovf=%b dcnt=%0d, need 0 0 1 1",
                     level, m_valid, overflow, drop_cnt);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 10'(i + 1), 1'b0, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd0) begin
            nerr++;
            $display("FAIL restart_warm: level=%0d, need 0", level);
        end
        v = 10'($urandom_range(0, 1023));
        step(1'b1, v, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd1 || m_data !== v) begin
            nerr++;
            $display("FAIL restart_ninth: level=%0d data=%h, need 1 %h", level, m_data, v);
        end
    endtask

    task automatic test_clr_race();
        do_reset();
        warm();
        for (int i = 0; i < 19; i++) step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h111, 1'b0, 1'b0, 1'b1);
        nvec++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL clr_race: ovf=%b dcnt=%0d, need 1 1", overflow, drop_cnt);
        end
        for (int i = 0; i < 300; i++) step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
        nvec++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
            nerr++;
            $display("FAIL saturate: dcnt=%0d ovf=%b, need 255 1", drop_cnt, overflow);
        end
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        nvec++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0 || level !== 5'd16) begin
            nerr++;
            $display("FAIL clr: dcnt=%0d ovf=%b level=%0d, need 0 0 16", drop_cnt, overflow, level);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        warm();
        for (int i = 0; i < 7; i++) step(1'b1, 10'(i + 1), 1'b0, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd7) begin
            nerr++;
            $display("FAIL async_pre: level=%0d, need 7", level);
        end
        #2 reset = 1'b0;
        #1;
        model_clear();
        nvec++;
        if (m_valid !== 1'b0 || m_data !== 10'd0 || level !== 5'd0 ||
            overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL async_reset: valid=%b data=%h level=%0d ovf=%b dcnt=%0d, need all 0",
                     m_valid, m_data, level, overflow, drop_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 10'h0AB, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (level !== 5'd0) begin
            nerr++;
            $display("FAIL async_rewarm: level=%0d, need 0", level);
        end
    endtask

    task automatic test_random();
        logic       e, r, rs, c;
        logic [9:0] v;
        logic [9:0] exp_d;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            e  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 99) == 0);
            v  = 10'($urandom_range(0, 1023));
            step(e, v, r, rs, c);
            exp_d = (q.size() != 0) ? q[0] : 10'd0;
            nvec++;
            if (m_valid !== (q.size() != 0) || m_data !== exp_d ||
                level !== 5'(q.size()) || overflow !== m_ovf || drop_cnt !== 8'(m_dcnt)) begin
                nerr++;
                $display("FAIL random[%0d]: v=%b d=%h l=%0d o=%b c=%0d, need %b %h %0d %b %0d",
                         n, m_valid, m_data, level, overflow, drop_cnt,
                         q.size() != 0, exp_d, q.size(), m_ovf, m_dcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_fill();
        test_full_pushpop();
        test_restart();
        test_clr_race();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
